// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//
// Debug read-out engine for the CPU register file. A Start pulse in IDLE walks
// read port A through registers 0..NUM_REGS-1. Each register gets one READ
// cycle so the asynchronous read can settle. The value is then captured and
// offered as one indexed beat on a valid/ready stream.
//
// Handshake: a beat transfers on a rising edge of Clk where DumpValid and
// DumpReady are both high. While DumpValid is high and DumpReady is low,
// DumpData, DumpIdx and DumpValid hold their values. DumpValid never drops
// without a transfer, except on Reset.
//
// Ports:
//   Clk       in   clock, all state changes on the rising edge
//   Reset     in   synchronous active-high reset, has priority over Start
//   Start     in   dump request, sampled only in IDLE
//   RA        out  [ADDR_W]  read address to register file port A
//   BusA      in   [DATA_W]  asynchronous read data from port A
//   DumpData  out  [DATA_W]  captured register value
//   DumpIdx   out  [ADDR_W]  index of DumpData
//   DumpValid out  beat valid
//   DumpReady in   consumer accepts the beat
//   DumpLast  out  valid beat carries the final index
//   Busy      out  high in READ and SEND
//   Done      out  one-cycle pulse after the final beat is accepted
//   DbgState  out  [2]  current FSM state (IDLE=0, READ=1, SEND=2, DONE=3)
// ---------------------------------------------------------------------------
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [ADDR_W-1:0] RA,
    input  logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] DumpData,
    output logic [ADDR_W-1:0] DumpIdx,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic              DumpLast,
    output logic              Busy,
    output logic              Done,
    output logic [1:0]        DbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } stateT;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] idx;
    logic              handshake;
    logic              atLast;

    assign handshake = DumpValid && DumpReady;
    assign atLast    = (idx == LAST_IDX);

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (Start) nextState = READ;
            READ: nextState = SEND;
            SEND: begin
                if (handshake) begin
                    nextState = atLast ? DONE : READ;
                end
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Index counter and beat registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            idx       <= '0;
            DumpData  <= '0;
            DumpIdx   <= '0;
            DumpValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) idx <= '0;
                end
                READ: begin
                    // RA has been stable for this whole cycle, so BusA is settled.
                    DumpData  <= BusA;
                    DumpIdx   <= idx;
                    DumpValid <= 1'b1;
                end
                SEND: begin
                    if (handshake) begin
                        DumpValid <= 1'b0;
                        // The last index leaves SEND without incrementing, so idx never wraps.
                        if (!atLast) idx <= idx + ADDR_W'(1);
                    end
                end
                DONE: begin
                    // Clear the beat registers so that every output reads 0 back in IDLE.
                    idx      <= '0;
                    DumpData <= '0;
                    DumpIdx  <= '0;
                end
                default: begin
                    idx <= '0;
                end
            endcase
        end
    end

    // RA follows idx while a dump is active and is 0 otherwise.
    assign RA       = (state == READ || state == SEND) ? idx : '0;
    assign DumpLast = DumpValid && (DumpIdx == LAST_IDX);
    assign Busy     = (state == READ) || (state == SEND);
    assign Done     = (state == DONE);
    assign DbgState = state;

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic [ADDR_W-1:0] RA;
    logic [DATA_W-1:0] BusA;
    logic [DATA_W-1:0] DumpData;
    logic [ADDR_W-1:0] DumpIdx;
    logic              DumpValid;
    logic              DumpReady;
    logic              DumpLast;
    logic              Busy;
    logic              Done;
    logic [1:0]        DbgState;

    // Register file model with an asynchronous read port A
    logic [DATA_W-1:0] regs [NUM_REGS];
    assign BusA = regs[RA];

    // Expected beat values, in order
    logic [DATA_W-1:0] exp_q[$];

    int checkCount = 0;
    int errorCount = 0;

    regfile_dump #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .RA       (RA),
        .BusA     (BusA),
        .DumpData (DumpData),
        .DumpIdx  (DumpIdx),
        .DumpValid(DumpValid),
        .DumpReady(DumpReady),
        .DumpLast (DumpLast),
        .Busy     (Busy),
        .Done     (Done),
        .DbgState (DbgState)
    );

    // Clock and time limit
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance one clock and sample #1 after the rising edge
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_ra"},    32'(RA),        32'd0);
        checkVal({tag, "_data"},  DumpData,       32'd0);
        checkVal({tag, "_idx"},   32'(DumpIdx),   32'd0);
        checkVal({tag, "_valid"}, 32'(DumpValid), 32'd0);
        checkVal({tag, "_last"},  32'(DumpLast),  32'd0);
        checkVal({tag, "_busy"},  32'(Busy),      32'd0);
        checkVal({tag, "_done"},  32'(Done),      32'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = (i == 0) ? 32'h0 : (32'h1000_0000 + 32'(i));
        end
    endtask

    // One full dump starting now; cyc counts edges after the Start edge k.
    task automatic runDump(input int stallIdx, input int stallLen, input bit pokeStart, input bit writeReg3);
        int cyc;
        int beats;
        int dones;
        int doneCyc;
        int stalled;
        bit written;
        logic [DATA_W-1:0] holdData;
        logic [ADDR_W-1:0] holdIdx;
        logic [DATA_W-1:0] expData;

        cyc = 0; beats = 0; dones = 0; doneCyc = 0; stalled = 0; written = 1'b0;
        holdData = '0; holdIdx = '0;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            exp_q.push_back((writeReg3 && i == 3) ? 32'hDEAD_BEEF : regs[i]);
        end

        DumpReady = 1'b1;
        Start = 1'b1;
        step();
        Start = 1'b0;
        checkVal("start_busy",  32'(Busy),      32'd1);
        checkVal("start_ra",    32'(RA),        32'd0);
        checkVal("start_valid", 32'(DumpValid), 32'd0);

        while (cyc < 300 && !(dones > 0 && cyc >= doneCyc + 3)) begin
            Start = 1'b0;
            if (DumpValid) begin
                if (32'(DumpIdx) == stallIdx && stalled < stallLen) begin
                    if (stalled == 0) begin
                        holdData = DumpData;
                        holdIdx  = DumpIdx;
                    end else begin
                        checkVal("stall_data", DumpData, holdData);
                        checkVal("stall_idx",  32'(DumpIdx), 32'(holdIdx));
                    end
                    DumpReady = 1'b0;
                    stalled++;
                end else begin
                    DumpReady = 1'b1;
                    if (exp_q.size() == 0) begin
                        checkVal("extra_beat", 32'(beats), 32'(NUM_REGS));
                    end else begin
                        expData = exp_q.pop_front();
                        checkVal("beat_idx",  32'(DumpIdx),  32'(beats));
                        checkVal("beat_data", DumpData,      expData);
                        checkVal("beat_last", 32'(DumpLast), 32'(beats == NUM_REGS - 1));
                    end
                    if (pokeStart && DumpIdx == 5'd4) Start = 1'b1;
                    beats++;
                end
            end else begin
                checkVal("last_without_valid", 32'(DumpLast), 32'd0);
            end
            if (Done) begin
                dones++;
                doneCyc = cyc;
                checkVal("done_busy", 32'(Busy), 32'd0);
                if (pokeStart) Start = 1'b1;
            end
            if (writeReg3 && !written && Busy && !DumpValid && RA == 5'd3) begin
                @(negedge Clk);
                regs[3] = 32'hDEAD_BEEF;
                written = 1'b1;
            end
            step();
            cyc++;
        end
        Start = 1'b0;
        DumpReady = 1'b1;

        checkVal("beat_count",  32'(beats),     32'(NUM_REGS));
        checkVal("done_count",  32'(dones),     32'd1);
        checkVal("done_cycle",  32'(doneCyc),   32'(2 * NUM_REGS + stallLen));
        checkVal("end_busy",    32'(Busy),      32'd0);
        checkVal("end_valid",   32'(DumpValid), 32'd0);
        checkVal("end_state",   32'(DbgState),  32'd0);
        if (stallLen > 0) checkVal("stall_cycles", 32'(stalled), 32'(stallLen));
        if (writeReg3) checkVal("write_done", 32'(written), 32'd1);
    endtask

    initial begin
        int waitCyc;
        int doneSeen;
        bit found;

        Reset = 1'b1;
        Start = 1'b1;
        DumpReady = 1'b1;
        preload();

        // Reset held with Start high: everything stays 0
        for (int i = 0; i < 3; i++) begin
            step();
            checkAllZero("reset");
        end
        checkVal("reset_state", 32'(DbgState), 32'd0);
        Reset = 1'b0;
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("idle_valid", 32'(DumpValid), 32'd0);
            checkVal("idle_busy",  32'(Busy),      32'd0);
        end

        // Full dump, consumer always ready
        runDump(-1, 0, 1'b0, 1'b0);

        // Backpressure on beat 7 for 5 cycles
        runDump(7, 5, 1'b0, 1'b0);

        // Start pulses at beat 4 and in the DONE cycle are ignored
        runDump(-1, 0, 1'b1, 1'b0);

        // Register 3 written just before its capture edge
        runDump(-1, 0, 1'b0, 1'b1);
        preload();

        // Reset while beat 10 is valid
        Start = 1'b1;
        step();
        Start = 1'b0;
        found = 1'b0;
        waitCyc = 0;
        while (!found && waitCyc < 100) begin
            if (DumpValid && DumpIdx == 5'd10) found = 1'b1;
            else begin
                step();
                waitCyc++;
            end
        end
        checkVal("abort_found", 32'(found), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkAllZero("abort");
        doneSeen = 0;
        for (int i = 0; i < 70; i++) begin
            if (Done || DumpValid || Busy) doneSeen++;
            step();
        end
        checkVal("abort_quiet", 32'(doneSeen), 32'd0);

        // Fresh dump restarts from index 0
        runDump(-1, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
